// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding, lamp codes and default durations
package traffic_pkg;

    // Listed order fixes the Phase debug encoding 0..6.
    typedef enum logic [2:0] {
        CLEAR_M     = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        CLEAR_S     = 3'd3,
        PED_WALK    = 3'd4,
        SIDE_GREEN  = 3'd5,
        SIDE_YELLOW = 3'd6
    } phase_t;

    // Lamp vectors are {R,Y,G}, one-hot.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Default durations in seconds.
    localparam int DEF_MAIN_GREEN = 9;
    localparam int DEF_SIDE_GREEN = 6;
    localparam int DEF_YELLOW     = 3;
    localparam int DEF_ALL_RED    = 1;
    localparam int DEF_WALK       = 5;

    // A zero duration would expire at once; anything above 15 does not fit the Timer.
    function automatic bit dur_ok(input int d);
        return (d >= 1) && (d <= 15);
    endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// rtl/traffic_phase_controller_if.sv - handshake between phase sequencer and seconds Timer
// Timer_Value   : duration to load for the phase being entered
// Start_Timer   : one-cycle start pulse
// Timer_Expired : expiry pulse back from the Timer
interface traffic_phase_controller_if;

    logic [3:0] Timer_Value;
    logic       Start_Timer;
    logic       Timer_Expired;

    // master: the phase sequencer; slave: the Timer
    modport master (output Timer_Value, output Start_Timer, input Timer_Expired);
    modport slave  (input Timer_Value, input Start_Timer, output Timer_Expired);

endinterface

// File: rtl/request_latch.sv
// rtl/request_latch.sv - sticky request flag with set inhibit and priority clear
// clk     : system clock
// rst     : synchronous active-high reset, clears the flag
// set     : request input, level or single-cycle pulse
// inhibit : blocks set while the request is being served
// clear   : request served; beats a simultaneous set
// pend    : registered pending flag
module request_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic inhibit,
    input  logic clear,
    output logic pend
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pend <= 1'b0;
        end else if (set && !inhibit) begin
            pend <= 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - intersection phase sequencer driving the seconds Timer
// clk          : system clock
// Sync_Reset   : synchronous active-high reset
// tmr          : Timer handshake (Timer_Value, Start_Timer out; Timer_Expired in)
// Side_Request : side-road vehicle sensor
// Ped_Request  : pedestrian button
// Main_Light   : main-road lamps {R,Y,G}
// Side_Light   : side-road lamps {R,Y,G}
// Walk         : pedestrian walk lamp
// Phase        : current phase encoding
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int T_MAIN_GREEN = DEF_MAIN_GREEN,
    parameter int T_SIDE_GREEN = DEF_SIDE_GREEN,
    parameter int T_YELLOW     = DEF_YELLOW,
    parameter int T_ALL_RED    = DEF_ALL_RED,
    parameter int T_WALK       = DEF_WALK
) (
    input  logic                       clk,
    input  logic                       Sync_Reset,
    traffic_phase_controller_if.master tmr,
    input  logic                       Side_Request,
    input  logic                       Ped_Request,
    output logic [2:0]                 Main_Light,
    output logic [2:0]                 Side_Light,
    output logic                       Walk,
    output logic [2:0]                 Phase
);

    if (!dur_ok(T_MAIN_GREEN) || !dur_ok(T_SIDE_GREEN) || !dur_ok(T_YELLOW) ||
        !dur_ok(T_ALL_RED) || !dur_ok(T_WALK)) begin : g_bad_duration
        $error("traffic_phase_controller: every duration must lie in 1..15");
    end

    localparam logic [3:0] D_MAIN_GREEN = 4'(T_MAIN_GREEN);
    localparam logic [3:0] D_SIDE_GREEN = 4'(T_SIDE_GREEN);
    localparam logic [3:0] D_YELLOW     = 4'(T_YELLOW);
    localparam logic [3:0] D_ALL_RED    = 4'(T_ALL_RED);
    localparam logic [3:0] D_WALK       = 4'(T_WALK);

    phase_t     state;
    phase_t     state_nxt;
    logic       boot;
    logic       advance;
    logic       side_pend;
    logic       ped_pend;
    logic [2:0] main_nxt;
    logic [2:0] side_nxt;
    logic       walk_nxt;
    logic [3:0] value_nxt;

    // An expiry seen while Start_Timer is high belongs to the previous phase.
    assign advance = tmr.Timer_Expired && !tmr.Start_Timer;

    always_comb begin
        state_nxt = state;
        if (advance) begin
            case (state)
                CLEAR_M:     state_nxt = MAIN_GREEN;
                MAIN_GREEN:  state_nxt = (side_pend || ped_pend) ? MAIN_YELLOW : MAIN_GREEN;
                MAIN_YELLOW: state_nxt = CLEAR_S;
                CLEAR_S:     state_nxt = ped_pend ? PED_WALK : SIDE_GREEN;
                PED_WALK:    state_nxt = side_pend ? SIDE_GREEN : CLEAR_M;
                SIDE_GREEN:  state_nxt = SIDE_YELLOW;
                SIDE_YELLOW: state_nxt = CLEAR_M;
                default:     state_nxt = CLEAR_M;
            endcase
        end
    end

    // Decode the phase being entered so lamps and duration come out of flops.
    always_comb begin
        main_nxt  = LAMP_R;
        side_nxt  = LAMP_R;
        walk_nxt  = 1'b0;
        value_nxt = D_ALL_RED;
        case (state_nxt)
            CLEAR_M:     value_nxt = D_ALL_RED;
            MAIN_GREEN:  begin main_nxt = LAMP_G; value_nxt = D_MAIN_GREEN; end
            MAIN_YELLOW: begin main_nxt = LAMP_Y; value_nxt = D_YELLOW;     end
            CLEAR_S:     value_nxt = D_ALL_RED;
            PED_WALK:    begin walk_nxt = 1'b1;   value_nxt = D_WALK;       end
            SIDE_GREEN:  begin side_nxt = LAMP_G; value_nxt = D_SIDE_GREEN; end
            SIDE_YELLOW: begin side_nxt = LAMP_Y; value_nxt = D_YELLOW;     end
            default:     value_nxt = D_ALL_RED;
        endcase
    end

    // boot marks the first cycle out of reset, which counts as an entry into CLEAR_M.
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            state           <= CLEAR_M;
            Main_Light      <= LAMP_R;
            Side_Light      <= LAMP_R;
            Walk            <= 1'b0;
            tmr.Timer_Value <= D_ALL_RED;
            tmr.Start_Timer <= 1'b0;
            boot            <= 1'b1;
        end else begin
            state           <= state_nxt;
            Main_Light      <= main_nxt;
            Side_Light      <= side_nxt;
            Walk            <= walk_nxt;
            tmr.Timer_Value <= value_nxt;
            tmr.Start_Timer <= advance || boot;
            boot            <= 1'b0;
        end
    end

    assign Phase = state;

    request_latch u_side_latch (
        .clk     (clk),
        .rst     (Sync_Reset),
        .set     (Side_Request),
        .inhibit ((state == SIDE_GREEN) || (state == SIDE_YELLOW)),
        .clear   (advance && (state_nxt == SIDE_GREEN)),
        .pend    (side_pend)
    );

    request_latch u_ped_latch (
        .clk     (clk),
        .rst     (Sync_Reset),
        .set     (Ped_Request),
        .inhibit (state == PED_WALK),
        .clear   (advance && (state_nxt == PED_WALK)),
        .pend    (ped_pend)
    );

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - self-checking bench for traffic_phase_controller
module tb_traffic_phase_controller;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       Sync_Reset = 1'b1;
    logic       Side_Request = 1'b0;
    logic       Ped_Request = 1'b0;
    logic [2:0] Main_Light;
    logic [2:0] Side_Light;
    logic       Walk;
    logic [2:0] Phase;

    traffic_phase_controller_if tif ();

    traffic_phase_controller dut (
        .clk          (clk),
        .Sync_Reset   (Sync_Reset),
        .tmr          (tif.master),
        .Side_Request (Side_Request),
        .Ped_Request  (Ped_Request),
        .Main_Light   (Main_Light),
        .Side_Light   (Side_Light),
        .Walk         (Walk),
        .Phase        (Phase)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Timer model: expires Value cycles after its start pulse.
    int tcnt = 0;
    bit stretch = 0;
    bit hold = 0;
    bit noise_en = 0;
    bit t_exp;
    always @(negedge clk) begin
        t_exp = 1'b0;
        if (Sync_Reset) begin
            tcnt = 0;
            hold = 0;
        end else begin
            if (hold) begin
                t_exp = 1'b1;
                hold  = 0;
            end
            if (tif.Start_Timer) begin
                tcnt = int'(tif.Timer_Value);
            end else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) begin
                    t_exp = 1'b1;
                    if (stretch) begin
                        hold    = 1;
                        stretch = 0;
                    end
                end
            end
            if (noise_en && ($urandom_range(0, 15) == 0)) t_exp = 1'b1;
        end
        tif.Timer_Expired = t_exp;
    end

    // Reference model: phase index 0..6 in the listed order, tables per phase.
    int         dur_tbl  [7] = '{1, 9, 3, 1, 5, 6, 3};
    logic [2:0] main_tbl [7] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tbl [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
    bit         walk_tbl [7] = '{0, 0, 0, 0, 1, 0, 0};

    function automatic int next_phase(input int ph, input bit sp, input bit pp);
        case (ph)
            0: return 1;
            1: return (sp || pp) ? 2 : 1;
            2: return 3;
            3: return pp ? 4 : 5;
            4: return sp ? 5 : 0;
            5: return 6;
            default: return 0;
        endcase
    endfunction

    int m_ph = 0;
    bit m_sp = 0, m_pp = 0, m_start = 0, m_after_rst = 0, checking = 0;

    always @(posedge clk) begin
        bit adv;
        int nph;
        bit nsp, npp;
        if (Sync_Reset) begin
            m_ph = 0; m_sp = 0; m_pp = 0; m_start = 0;
            m_after_rst = 1; checking = 1;
        end else if (checking) begin
            adv = tif.Timer_Expired && !m_start;
            nph = adv ? next_phase(m_ph, m_sp, m_pp) : m_ph;
            nsp = m_sp || (Side_Request && m_ph != 5 && m_ph != 6);
            npp = m_pp || (Ped_Request && m_ph != 4);
            if (adv && nph == 5) nsp = 0;
            if (adv && nph == 4) npp = 0;
            m_start = adv || m_after_rst;
            m_after_rst = 0;
            m_ph = nph; m_sp = nsp; m_pp = npp;
        end
        #1;
        if (checking) begin
            chk("phase", Phase, m_ph);
            chk("main_light", Main_Light, main_tbl[m_ph]);
            chk("side_light", Side_Light, side_tbl[m_ph]);
            chk("walk", Walk, walk_tbl[m_ph]);
            chk("timer_value", tif.Timer_Value, dur_tbl[m_ph]);
            chk("start_timer", tif.Start_Timer, m_start);
            chk("side_pend", dut.side_pend, m_sp);
            chk("ped_pend", dut.ped_pend, m_pp);
        end
    end

    task automatic wait_start(input int val, input bit wk, input string nm);
        int n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!tif.Start_Timer && n < 300);
        chk({nm, "_seen"}, tif.Start_Timer, 1);
        chk({nm, "_value"}, tif.Timer_Value, val);
        chk({nm, "_walk"}, Walk, wk);
    endtask

    int seq_side [6] = '{3, 1, 6, 3, 1, 9};
    int seq_both [7] = '{3, 1, 5, 6, 3, 1, 9};

    initial begin
        // Reset state
        Sync_Reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_phase", Phase, 0);
        chk("rst_main", Main_Light, 3'b100);
        chk("rst_side", Side_Light, 3'b100);
        chk("rst_walk", Walk, 0);
        chk("rst_value", tif.Timer_Value, 1);
        chk("rst_start", tif.Start_Timer, 0);
        @(negedge clk) Sync_Reset = 1'b0;
        @(posedge clk); #2;
        chk("boot_start", tif.Start_Timer, 1);
        chk("boot_value", tif.Timer_Value, 1);

        // No requests: MAIN_GREEN re-arms
        wait_start(9, 0, "mg_first");
        chk("mg_first_main", Main_Light, 3'b001);
        wait_start(9, 0, "mg_rearm");
        chk("mg_rearm_side", Side_Light, 3'b100);
        chk("mg_rearm_phase", Phase, 1);

        // One-cycle side pulse
        repeat (3) @(negedge clk);
        Side_Request = 1'b1;
        @(negedge clk) Side_Request = 1'b0;
        foreach (seq_side[i]) wait_start(seq_side[i], 0, "side_seq");

        // Ped and side together: ped served first
        @(negedge clk) begin Side_Request = 1'b1; Ped_Request = 1'b1; end
        @(negedge clk) begin Side_Request = 1'b0; Ped_Request = 1'b0; end
        foreach (seq_both[i]) wait_start(seq_both[i], seq_both[i] == 5, "both_seq");
        chk("both_side_pend_clr", dut.side_pend, 0);
        chk("both_ped_pend_clr", dut.ped_pend, 0);

        // Expiry held through the MAIN_YELLOW start cycle
        @(negedge clk) begin Side_Request = 1'b1; stretch = 1; end
        @(negedge clk) Side_Request = 1'b0;
        wait_start(3, 0, "stale_yel");
        chk("stale_yel_phase", Phase, 2);
        @(posedge clk); #2;
        chk("stale_hold_phase", Phase, 2);
        chk("stale_hold_start", tif.Start_Timer, 0);
        wait_start(1, 0, "stale_clr_s");
        chk("stale_clr_s_phase", Phase, 3);
        wait_start(6, 0, "stale_side_green");

        // Reset mid SIDE_GREEN with a pending ped request
        @(negedge clk) begin Ped_Request = 1'b1; Side_Request = 1'b1; end
        @(negedge clk) begin Ped_Request = 1'b0; Side_Request = 1'b0; end
        chk("sg_ped_pend_set", dut.ped_pend, 1);
        Sync_Reset = 1'b1;
        @(posedge clk); #2;
        chk("mid_rst_main", Main_Light, 3'b100);
        chk("mid_rst_side", Side_Light, 3'b100);
        chk("mid_rst_walk", Walk, 0);
        chk("mid_rst_value", tif.Timer_Value, 1);
        chk("mid_rst_side_pend", dut.side_pend, 0);
        chk("mid_rst_ped_pend", dut.ped_pend, 0);
        chk("mid_rst_start", tif.Start_Timer, 0);
        @(negedge clk) Sync_Reset = 1'b0;
        @(posedge clk); #2;
        chk("mid_rst_boot_start", tif.Start_Timer, 1);

        // Ped held through PED_WALK: re-latched once out of it
        wait_start(9, 0, "hold_mg");
        @(negedge clk) Ped_Request = 1'b1;
        wait_start(3, 0, "hold_yel");
        wait_start(1, 0, "hold_clr_s");
        wait_start(5, 1, "hold_walk");
        @(posedge clk); #2;
        chk("hold_walk_ped_pend", dut.ped_pend, 0);
        wait_start(1, 0, "hold_clr_m");
        chk("hold_clr_m_phase", Phase, 0);
        @(posedge clk); #2;
        chk("hold_clr_m_ped_pend", dut.ped_pend, 1);
        @(negedge clk) Ped_Request = 1'b0;
        wait_start(9, 0, "again_mg");
        wait_start(3, 0, "again_yel");
        wait_start(1, 0, "again_clr_s");
        wait_start(5, 1, "again_walk");
        chk("again_walk_phase", Phase, 4);

        // Randomised traffic with stray expiry pulses and occasional resets
        noise_en = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            Side_Request = ($urandom_range(0, 11) == 0);
            Ped_Request  = ($urandom_range(0, 15) == 0);
            Sync_Reset   = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk) begin
            Sync_Reset = 1'b0; Side_Request = 1'b0; Ped_Request = 1'b0; noise_en = 0;
        end
        repeat (3) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
